// File: rtl/lenet_pkg.sv
// Shared types for the LeNet C1/S2 pixel-stream interface.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package lenet_pkg;

   typedef logic signed [7:0] pixel_t;

   localparam int LENET_MAPSIZE = 32;

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_STREAM,
      S_DONE
   } stream_state_e;

endpackage

// File: rtl/frame_buffer_ram.sv
// Simple dual-port frame store: one write port, one registered read port.
// Latency: 1 cycle read; read-during-write to one address returns the old word.
// Backpressure: none, accepts a write and a read every cycle.
module frame_buffer_ram #(
   parameter  int DEPTH = 1024,
   parameter  int WIDTH = 8,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/lenet_frame_streamer.sv
// Holds one MAPSIZE x MAPSIZE frame and streams it row-major to the C1/S2 channels on go.
// Latency: start one cycle after go, pixel 0 the cycle after, then one beat per GAP_CYCLES+1.
// Backpressure: none downstream; go is ignored and writes are rejected while busy.
module lenet_frame_streamer
   import lenet_pkg::*;
#(
   parameter int MAPSIZE    = LENET_MAPSIZE,
   parameter int GAP_CYCLES = 0,
   parameter int ADDR_W     = $clog2(MAPSIZE*MAPSIZE)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               wr_en,
   input  logic [ADDR_W-1:0]  wr_addr,
   input  logic signed [7:0]  wr_data,
   input  logic               go,
   output logic               busy,
   output logic               start,
   output logic               data_valid_out,
   output logic signed [7:0]  pixel_out,
   output logic               frame_done,
   output logic               wr_err
);

   localparam int NPIX   = MAPSIZE*MAPSIZE;
   localparam int RAM_AW = $clog2(NPIX);
   localparam int GAP_W  = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES+1) : 1;

   localparam logic [ADDR_W:0]  NPIX_C   = (ADDR_W+1)'(NPIX);
   localparam logic [ADDR_W:0]  LAST_PIX = (ADDR_W+1)'(NPIX-1);
   localparam logic [ADDR_W:0]  PIX_ONE  = (ADDR_W+1)'(1);
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);
   localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

   stream_state_e    state_q, state_d;
   logic [ADDR_W:0]  pix_q, pix_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic             valid_q, valid_d;
   logic             start_q, busy_q, done_q, err_q;
   logic             busy_now, wr_in_range, wr_ok, wr_bad;
   logic [7:0]       ram_rdata;

   // START counts as busy, which also covers rejecting writes while start is high
   assign busy_now    = (state_q == S_START) || (state_q == S_STREAM);
   assign wr_in_range = {1'b0, wr_addr} < NPIX_C;
   assign wr_ok       = wr_en && !busy_now && wr_in_range && !rst;
   assign wr_bad      = wr_en && (busy_now || !wr_in_range);

   always_comb begin
      state_d = state_q;
      pix_d   = pix_q;
      gap_d   = gap_q;
      valid_d = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: begin
            state_d = go ? S_START : S_IDLE;
         end
         S_START: begin
            state_d = S_STREAM;
            pix_d   = '0;
            gap_d   = '0;
            valid_d = 1'b1;
         end
         S_STREAM: begin
            if (valid_q) begin
               if (pix_q == LAST_PIX) begin
                  state_d = S_DONE;
               end else if (GAP_CYCLES == 0) begin
                  pix_d   = pix_q + PIX_ONE;
                  valid_d = 1'b1;
               end else begin
                  gap_d = GAP_LOAD;
               end
            end else begin
               gap_d = gap_q - GAP_ONE;
               if (gap_q == GAP_ONE) begin
                  pix_d   = pix_q + PIX_ONE;
                  valid_d = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         pix_q   <= '0;
         gap_q   <= '0;
         valid_q <= 1'b0;
         start_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pix_q   <= pix_d;
         gap_q   <= gap_d;
         valid_q <= valid_d;
         start_q <= (state_d == S_START);
         busy_q  <= (state_d == S_START) || (state_d == S_STREAM);
         done_q  <= (state_d == S_DONE);
         err_q   <= wr_bad;
      end
   end

   // Read address runs one cycle ahead of the beat, so the RAM output register is the pixel register
   frame_buffer_ram #(
      .DEPTH (NPIX),
      .WIDTH (8)
   ) u_ram (
      .clk   (clk),
      .we    (wr_ok),
      .waddr (wr_addr[RAM_AW-1:0]),
      .wdata (wr_data),
      .raddr (pix_d[RAM_AW-1:0]),
      .rdata (ram_rdata)
   );

   assign busy           = busy_q;
   assign start          = start_q;
   assign data_valid_out = valid_q;
   assign pixel_out      = valid_q ? pixel_t'(ram_rdata) : pixel_t'(0);
   assign frame_done     = done_q;
   assign wr_err         = err_q;

endmodule
